// File: rtl/regfile_op_sequencer_pkg.sv
// regfile_op_sequencer_pkg
// Shared definitions for the regfile/ALU command sequencer and everything that
// talks to it: default widths, command-type codes, FSM state encodings and
// the alucontrol opcodes understood by the alu.
package regfile_op_sequencer_pkg;

  // Default datapath widths
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 3;

  // Command types carried on cmd_type
  localparam logic CMD_ALU = 1'b0;
  localparam logic CMD_LI  = 1'b1;

  // Sequencer state encodings
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_READ   = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;
  localparam logic [2:0] ST_VERIFY = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_READ   = ST_READ,
    S_EXEC   = ST_EXEC,
    S_WRITE  = ST_WRITE,
    S_DONE   = ST_DONE,
    S_VERIFY = ST_VERIFY
  } state_t;

  // alucontrol opcodes; the sequencer passes these through untouched
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
// Accepts one register-level command at a time (ALU op rd = rs op rt, or
// load-immediate rd = imm), sequences the regfile read ports, alucontrol and
// the regfile write port, then pulses done with the written value.
//
// Optional feature macro: SEQ_READBACK_EN
//   When defined, a VERIFY state follows WRITE (for rd != 0) that reads rd back
//   on read port 1 and sets the sticky readback_err flag on a mismatch.
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (ready only in IDLE)
//   cmd_type                   0 = ALU op, 1 = load-immediate
//   cmd_rd/rs/rt               destination and source register indices
//   cmd_alucontrol, cmd_imm    ALU opcode (opaque) and immediate value
//   read_reg1/2, alucontrol    to the regfile read ports and the alu
//   alu_result                 combinational result from the alu
//   read_data1                 regfile read port 1 data (SEQ_READBACK_EN only)
//   write_reg/data/enable      to the regfile write port
//   done, done_data            completion pulse and the value written
//   busy                       high whenever not IDLE
//   readback_err               sticky readback mismatch (SEQ_READBACK_EN only)
module regfile_op_sequencer
  import regfile_op_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_type,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs,
  input  logic [ADDR_W-1:0] cmd_rt,
  input  logic [CTRL_W-1:0] cmd_alucontrol,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] read_reg1,
  output logic [ADDR_W-1:0] read_reg2,
  output logic [CTRL_W-1:0] alucontrol,
  input  logic [DATA_W-1:0] alu_result,
`ifdef SEQ_READBACK_EN
  input  logic [DATA_W-1:0] read_data1,
  output logic              readback_err,
`endif
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              write_enable,
  output logic              done,
  output logic [DATA_W-1:0] done_data,
  output logic              busy
);

  state_t state_q, state_d;

  logic              type_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] done_data_q;
  logic [ADDR_W-1:0] read_reg1_q;
  logic [ADDR_W-1:0] read_reg2_q;
  logic [CTRL_W-1:0] alucontrol_q;
  logic              accept;
  logic [DATA_W-1:0] wval;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  // Value this command writes: the captured ALU result or the immediate.
  assign wval = (type_q == CMD_LI) ? imm_q : result_q;

  // State register; the write strobe decodes from it, so an asserted reset
  // drops write_enable immediately without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: ALU ops go READ -> EXEC -> WRITE, load-immediates skip
  // straight to WRITE; with readback enabled a non-r0 write is checked first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = (cmd_type == CMD_LI) ? S_WRITE : S_READ;
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
`ifdef SEQ_READBACK_EN
      S_WRITE: state_d = (rd_q != '0) ? S_VERIFY : S_DONE;
      S_VERIFY: state_d = S_DONE;
`else
      S_WRITE: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command latch and datapath registers. The read-port and alucontrol
  // registers double as the latch for rs/rt/alucontrol: they only load on an
  // ALU accept so they hold their last values across load-immediates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_q       <= CMD_ALU;
      rd_q         <= '0;
      imm_q        <= '0;
      result_q     <= '0;
      done_data_q  <= '0;
      read_reg1_q  <= '0;
      read_reg2_q  <= '0;
      alucontrol_q <= '0;
    end else begin
      if (accept) begin
        type_q <= cmd_type;
        rd_q   <= cmd_rd;
        imm_q  <= cmd_imm;
        if (cmd_type == CMD_ALU) begin
          read_reg1_q  <= cmd_rs;
          read_reg2_q  <= cmd_rt;
          alucontrol_q <= cmd_alucontrol;
        end
      end
      if (state_q == S_EXEC) result_q <= alu_result;
      if ((state_d == S_DONE) && (state_q != S_DONE)) done_data_q <= wval;
`ifdef SEQ_READBACK_EN
      if ((state_q == S_WRITE) && (state_d == S_VERIFY)) read_reg1_q <= rd_q;
`endif
    end
  end

`ifdef SEQ_READBACK_EN
  logic readback_err_q;

  // Sticky readback mismatch flag, only cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          readback_err_q <= 1'b0;
    else if ((state_q == S_VERIFY) && (read_data1 != wval)) readback_err_q <= 1'b1;
  end

  assign readback_err = readback_err_q;
`endif

  // r0 is immutable, so WRITE with rd == 0 keeps the strobe low.
  assign write_enable = (state_q == S_WRITE) && (rd_q != '0);
  assign write_reg    = write_enable ? rd_q : '0;
  assign write_data   = write_enable ? wval : '0;

  assign read_reg1  = read_reg1_q;
  assign read_reg2  = read_reg2_q;
  assign alucontrol = alucontrol_q;
  assign done       = (state_q == S_DONE);
  assign done_data  = done_data_q;
  assign busy       = (state_q != S_IDLE);
  assign cmd_ready  = (state_q == S_IDLE);

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
Command-driven initiator for the regfile/ALU datapath. It accepts one register-level command at a time: either an ALU op (rd = rs op rt) or a load-immediate (rd = imm). It drives the regfile read ports, alucontrol and the regfile write port, then signals completion. It sits between a per-core control/test source and the existing regfile plus combinational alu, and replaces hand-sequenced write/read/writeback stimulus.

Parameters:
DATA_W, 8, width of regfile data, ALU result and immediate
ADDR_W, 5, width of register indices
CTRL_W, 3, width of alucontrol

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_type  in  1  0 = ALU op, 1 = load-immediate
cmd_rd  in  ADDR_W  destination register
cmd_rs  in  ADDR_W  source A register (ALU op only)
cmd_rt  in  ADDR_W  source B register (ALU op only)
cmd_alucontrol  in  CTRL_W  ALU operation, passed through opaque
cmd_imm  in  DATA_W  immediate value (load-immediate only)
read_reg1  out  ADDR_W  to regfile read port 1
read_reg2  out  ADDR_W  to regfile read port 2
alucontrol  out  CTRL_W  to alu
alu_result  in  DATA_W  from alu (combinational from regfile reads)
write_reg  out  ADDR_W  to regfile write index
write_data  out  DATA_W  to regfile write data
write_enable  out  1  to regfile write strobe
done  out  1  one-cycle completion pulse
done_data  out  DATA_W  value written (or that would have been written) by the completed command
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. All outputs are 0 except cmd_ready=1. Latched command fields and the result register clear to 0.
- States: IDLE, READ, EXEC, WRITE, DONE. Handshake completes on a rising edge with cmd_valid & cmd_ready. cmd_ready = (state==IDLE).
- Accept at edge E0 latches all cmd_* fields. Transition to READ (ALU op) or WRITE (load-immediate).
- READ (1 cycle): read_reg1=rs, read_reg2=rt, alucontrol=latched value. Next state EXEC.
- EXEC (1 cycle): the same read/alucontrol values are held. alu_result is captured into result_q at the end of the cycle. Next state WRITE.
- WRITE (1 cycle): write_reg=rd, write_data=result_q (or imm for load-immediate), write_enable=1. Next state DONE.
- DONE (1 cycle): done=1, done_data=the written value (held until the next done). Next state IDLE.
- Latency from the accept edge: ALU op has write_enable in cycle 3 and done in cycle 4. Load-immediate has write_enable in cycle 1 and done in cycle 2. Throughput is one command per 5 or 3 cycles.
- cmd_* values are ignored while busy. cmd_valid may stay high; a held command is accepted on the first IDLE cycle.
- read_reg1, read_reg2 and alucontrol hold their last values outside READ/EXEC. write_reg and write_data are 0 when write_enable=0.
- rd=0: write_enable stays 0 during WRITE (r0 is immutable). done still pulses, and done_data=computed value.
- Arithmetic is done entirely by the alu; the result is truncated to DATA_W with no carry or overflow output.
- Dependent back-to-back commands need no forwarding, because the regfile write commits at the WRITE edge before the next READ.
- Reset mid-operation: the command is abandoned. If reset asserts during WRITE, write_enable drops immediately (asynchronously); no done pulse is produced.

Optional Feature:
Macro SEQ_READBACK_EN.
- Defined: after WRITE (and only when rd≠0), insert a VERIFY state. VERIFY drives read_reg1=rd for one cycle and compares read_data1 to the written value.
  - Adds input read_data1 (DATA_W) and output readback_err (1), a sticky flag cleared only by reset.
  - ALU-op latency to done becomes 5 cycles; load-immediate latency becomes 3.
- Undefined: no VERIFY state, no read_data1 or readback_err ports, and latencies are as above.

Decomposition:
- Shared package/header: state encodings (3-bit localparams), CMD_ALU/CMD_LI constants, DATA_W/ADDR_W/CTRL_W defaults, and ALU opcode constants (ADD=3'b000, etc.) reused by the alu and benches.
- No sub-module needed. The FSM and command latch sit in one module; the alu and regfile stay separate instances.

Test Plan:
- LI r1=94, then LI r2=12 -> write_enable in cycle 1 with write_reg=1, write_data=94; done in cycle 2; same pattern for r2=12.
- ALU op rd=3, rs=1, rt=2, alucontrol=0 (add) -> read_reg1=1 and read_reg2=2 in cycles 1-2; write_reg=3, write_data=106 in cycle 3; done_data=106 in cycle 4.
- Overflow: LI r4=200, LI r5=100, add r6=r4+r5 -> write_data=44 (8-bit wrap).
- Load-immediate with rd=0, imm=55 -> write_enable never asserts; done=1 with done_data=55. A subsequent read of r0 returns 0.
- Backpressure: cmd_valid held high with two different commands queued back-to-back -> cmd_ready=0 for cycles 1-4; the second command is accepted on the IDLE cycle after done; both writes occur in order.
- Assert reset during the WRITE cycle of an add -> write_enable falls without waiting for a clock edge, no done pulse, cmd_ready=1 after release, and the target register is unchanged.
